fsbm_search_ctrl: RTL

Sequencer for one full-search block-matching pass on a 4×4 block of 8-bit pixels. On `start`, it loads the current block, row by row, into the 4×4 block register. It then issues every candidate displacement in the search window to the PE array, in raster order. It compares the returned SAD values and reports the best motion vector and its SAD. It sits between the frame-buffer read port, the 4×4 block register and the PE/SAD-adder tree.

---
 rtl/fsbm_pkg.sv | 9 +
 rtl/fsbm_cand_gen.sv | 29 ++
 rtl/fsbm_search_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/fsbm_pkg.sv
// fsbm_pkg: shared state encoding, defaults and width helper for the block-matching sequencer
package fsbm_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SEARCH, DRAIN, DONE} state_t;
  localparam int WORD_W_DEF = 8;
  localparam int BLK_DIM = 4;
  function automatic int sad_width(input int word_width);
    return word_width + 4;
  endfunction
endpackage

// File: rtl/fsbm_cand_gen.sv
// fsbm_cand_gen: raster displacement counter, dx inner and dy outer, both spanning [-RANGE, RANGE-1]
module fsbm_cand_gen #(
  parameter int RANGE = 8,
  parameter int VW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  output logic signed [VW-1:0] dx,
  output logic signed [VW-1:0] dy,
  output logic                 last
);
  localparam logic signed [VW-1:0] LO = VW'(-RANGE);
  localparam logic signed [VW-1:0] HI = VW'(RANGE - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= LO;
      dy <= LO;
    end else if (step) begin
      dx <= dx == HI ? LO : dx + VW'(1);
      dy <= dx != HI ? dy : dy == HI ? LO : dy + VW'(1);
    end
  end
  assign last = dx == HI && dy == HI;
endmodule

// File: rtl/fsbm_search_ctrl.sv
// fsbm_search_ctrl: loads a 4x4 block, issues every search candidate in raster order and keeps the best SAD
module fsbm_search_ctrl
  import fsbm_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_W_DEF,
  parameter int RANGE = 8,
  parameter int SAD_WIDTH = 12,
  parameter int VW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 blk_rd_en,
  output logic [1:0]           blk_rd_row,
  output logic                 blk_en_input,
  output logic                 cand_valid,
  output logic signed [VW-1:0] cand_dx,
  output logic signed [VW-1:0] cand_dy,
  input  logic                 sad_valid,
  input  logic [SAD_WIDTH-1:0] sad,
  output logic signed [VW-1:0] best_dx,
  output logic signed [VW-1:0] best_dy,
  output logic [SAD_WIDTH-1:0] best_sad
);
  localparam int N = 4 * RANGE * RANGE;
  localparam int CW = $clog2(N) + 1;
  localparam logic signed [VW-1:0] LO = VW'(-RANGE);
  if (SAD_WIDTH < sad_width(WORD_WIDTH)) begin : g_bad_sad_width
    $error("SAD_WIDTH too small for WORD_WIDTH");
  end
  state_t state, nxt;
  logic [1:0] row;
  logic [CW-1:0] iss_cnt, rcv_cnt;
  logic signed [VW-1:0] iss_dx, iss_dy, rs_dx, rs_dy;
  logic iss_last, rs_last, start_acc, acc;
  assign start_acc = state == IDLE && start;
  assign acc = (state == SEARCH || state == DRAIN) && sad_valid && rcv_cnt != CW'(N);
  fsbm_cand_gen #(.RANGE(RANGE), .VW(VW)) u_iss (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .step(state == SEARCH),
    .dx(iss_dx), .dy(iss_dy), .last(iss_last)
  );
  // result-side twin tracks which candidate each returning SAD belongs to
  fsbm_cand_gen #(.RANGE(RANGE), .VW(VW)) u_rs (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .step(acc),
    .dx(rs_dx), .dy(rs_dy), .last(rs_last)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = row == 2'(BLK_DIM - 1) ? SETTLE : LOAD;
      SETTLE:  nxt = row == 2'd2 ? SEARCH : SETTLE;
      SEARCH:  nxt = iss_last ? DRAIN : SEARCH;
      DRAIN:   nxt = (acc && rs_last) || rcv_cnt == iss_cnt ? DONE : DRAIN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      iss_cnt      <= '0;
      rcv_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      blk_rd_en    <= 1'b0;
      blk_rd_row   <= '0;
      blk_en_input <= 1'b0;
      cand_valid   <= 1'b0;
      cand_dx      <= '0;
      cand_dy      <= '0;
      best_dx      <= '0;
      best_dy      <= '0;
      best_sad     <= '0;
    end else begin
      state        <= nxt;
      row          <= state == nxt ? row + 2'd1 : 2'd0;
      iss_cnt      <= start_acc ? '0 : iss_cnt + CW'(state == SEARCH);
      rcv_cnt      <= start_acc ? '0 : rcv_cnt + CW'(acc);
      busy         <= nxt != IDLE;
      done         <= nxt == DONE;
      blk_rd_en    <= state == LOAD;
      blk_rd_row   <= state == LOAD ? row : 2'd0;
      blk_en_input <= blk_rd_en;
      cand_valid   <= state == SEARCH;
      cand_dx      <= iss_dx;
      cand_dy      <= iss_dy;
      if (start_acc) begin
        best_sad <= '1;
        best_dx  <= LO;
        best_dy  <= LO;
      end else if (acc && sad < best_sad) begin
        best_sad <= sad;
        best_dx  <= rs_dx;
        best_dy  <= rs_dy;
      end
    end
  end
endmodule
